// File: rtl/jt51_wrq_if.sv
// Host/register-block signal bundle for jt51_wrq.
// master = environment (host plus register block), slave = the write queue.
interface jt51_wrq_if #(
    parameter int AW = 4
);
    logic          push;
    logic [7:0]    push_addr;
    logic [7:0]    push_data;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          ovf;
    logic          ovf_clr;
    logic          idle;
    logic          write;
    logic          a0;
    logic [7:0]    dout;
    logic          busy;

    modport master (
        output push, push_addr, push_data, ovf_clr, busy,
        input  full, empty, level, ovf, idle, write, a0, dout
    );

    modport slave (
        input  push, push_addr, push_data, ovf_clr, busy,
        output full, empty, level, ovf, idle, write, a0, dout
    );
endinterface

// File: rtl/jt51_wrq.sv
// JT51 host write queue: buffers (addr, data) writes and replays them as paced
// address/data strobes. Optional address-repeat skipping via JT51_WRQ_ADDRSKIP_EN.
module jt51_wrq #(
    parameter int AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    jt51_wrq_if.slave   bus
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP,
        S_DATA,
        S_HOLD,
        S_WAIT
    } state_t;

    logic [15:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  cur_addr_q, cur_addr_d;
    logic [7:0]  cur_data_q, cur_data_d;
    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic        a0_q, a0_d;
    logic [7:0]  dout_q, dout_d;
    logic        ovf_q, ovf_d;

    logic        full;
    logic        empty;
    logic        push_ok;
    logic        skip_addr;
    logic [15:0] head;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_ok = bus.push && !full;

    // Head is read combinationally so an entry pushed at edge n pops at edge n+1.
    assign head = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {bus.push_addr, bus.push_data};
        end
    end

`ifdef JT51_WRQ_ADDRSKIP_EN
    logic [7:0] last_addr_q;
    logic       last_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr_q  <= 8'h00;
            last_valid_q <= 1'b0;
        end else if (state_q == S_ADDR) begin
            last_addr_q  <= cur_addr_q;
            last_valid_q <= 1'b1;
        end
    end

    assign skip_addr = last_valid_q && (head[15:8] == last_addr_q);
`else
    assign skip_addr = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        // A dropped push wins over a same-cycle clear.
        ovf_d = ovf_q;
        if (bus.push && full) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        cur_addr_d = cur_addr_q;
        cur_data_d = cur_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    cur_addr_d = head[15:8];
                    cur_data_d = head[7:0];
                    state_d    = skip_addr ? S_GAP : S_ADDR;
                end
            end
            S_ADDR: state_d = S_GAP;
            S_GAP: begin
                if (!bus.busy) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: state_d = S_HOLD;
            S_HOLD: begin
                if (bus.busy) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe outputs are registered one cycle behind the state that requests them.
    always_comb begin
        write_d = 1'b0;
        a0_d    = a0_q;
        dout_d  = dout_q;
        if (state_q == S_ADDR) begin
            write_d = 1'b1;
            a0_d    = 1'b0;
            dout_d  = cur_addr_q;
        end else if (state_q == S_DATA) begin
            write_d = 1'b1;
            a0_d    = 1'b1;
            dout_d  = cur_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cur_addr_q <= 8'h00;
            cur_data_q <= 8'h00;
            state_q    <= S_IDLE;
            write_q    <= 1'b0;
            a0_q       <= 1'b0;
            dout_q     <= 8'h00;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cur_addr_q <= cur_addr_d;
            cur_data_q <= cur_data_d;
            state_q    <= state_d;
            write_q    <= write_d;
            a0_q       <= a0_d;
            dout_q     <= dout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.level = wr_ptr_q - rd_ptr_q;
    assign bus.ovf   = ovf_q;
    assign bus.idle  = empty && (state_q == S_IDLE);
    assign bus.write = write_q;
    assign bus.a0    = a0_q;
    assign bus.dout  = dout_q;
endmodule

// File: doc/jt51_wrq.md
# jt51_wrq

Host write queue and sequencer placed directly upstream of the JT51 memory-mapped register block. It buffers (address, data) register writes from a fast host, then replays each one on the register block's `write`/`a0`/`din` port as an address write followed by a data write. It paces data writes against the register block's `busy` output so that no write is lost while the chip is busy.

## Interface
Parameters:
- `AW`, 4: FIFO address width. Depth is 2^AW entries of 16 bits each.

Ports:
- `rst`  in  1  reset. Synchronous, active-high.
- `clk`  in  1  clock. This is the only clock in the block.
- `push`  in  1  host enqueue strobe. Sampled on every `clk` edge.
- `push_addr`  in  8  register address to enqueue.
- `push_data`  in  8  register data to enqueue.
- `full`  out  1  queue holds 2^AW entries.
- `empty`  out  1  queue holds 0 entries.
- `level`  out  AW+1  current number of entries.
- `ovf`  out  1  sticky flag: a push was dropped.
- `ovf_clr`  in  1  clears `ovf`.
- `idle`  out  1  queue is empty and the sequencer is in IDLE.
- `write`  out  1  write strobe to the register block.
- `a0`  out  1  0 selects an address write, 1 selects a data write.
- `dout`  out  8  value driven to the register block `din`.
- `busy`  in  1  busy flag from the register block.

## Operation
- The FIFO is a circular buffer with read and write pointers of AW+1 bits each.
  - `full` and `empty` are combinational functions of the registered pointers.
  - `level` = wr_ptr − rd_ptr, taken modulo 2^(AW+1).
- Push:
  - When `push` & !`full`, the entry {addr, data} is written at wr_ptr and wr_ptr increments.
  - When `push` & `full`, the entry is dropped and `ovf` is set.
  - `full` reflects the state before any same-cycle pop, so a push into a full queue is dropped even if a pop occurs in the same cycle.
- `ovf_clr` clears `ovf`. If `ovf_clr` and a dropped push occur in the same cycle, `ovf` ends up 1 (set wins).
- Sequencer states: IDLE, ADDR, GAP, DATA, HOLD, WAIT.
  - IDLE: `write`=0. If !`empty`, pop the head into cur_addr/cur_data, increment rd_ptr, and go to ADDR.
  - ADDR: `write`=1, `a0`=0, `dout`=cur_addr. Go to GAP.
  - GAP: `write`=0, `dout` holds. Go to DATA. This low cycle is required because the register block arms `busy` on a rising edge of `write` with `a0`=1.
  - DATA: `write`=1, `a0`=1, `dout`=cur_data. Go to HOLD.
  - HOLD: `write`=0. Wait until `busy`=1, then go to WAIT.
  - WAIT: `write`=0. Wait until `busy`=0, then go to IDLE.
- Before issuing DATA, the sequencer additionally waits in GAP while `busy`=1. This guards against a `busy` left high by an external writer.
- The sequencer never asserts `write` for more than one consecutive cycle.
- The sequencer holds `a0` and `dout` at their last values in all states where `write`=0.
- Reset: all of the following are applied synchronously on `rst`:
  - pointers = 0
  - state = IDLE
  - `write` = 0, `a0` = 0, `dout` = 8'h00
  - `ovf` = 0
  - resulting outputs: `full`=0, `empty`=1, `level`=0, `idle`=1
- Reset in the middle of a transaction abandons that transaction and all queued entries. No further strobe is issued after reset.

## Timing
- `write`, `a0` and `dout` are registered outputs.
- Latency from a push into an idle, empty queue to the address strobe:
  - push accepted at edge n
  - pop at edge n+1
  - `write`=1 with `a0`=0 is visible after edge n+2
- Minimum spacing between consecutive data strobes: 6 cycles plus the duration of `busy`.
- `busy` is expected to rise 1 cycle after the DATA strobe. HOLD has no timeout.
- Push and pop may occur in the same cycle when the queue is neither full nor empty. In that case `level` is unchanged.

## Configuration
- `JT51_WRQ_ADDRSKIP_EN`:
  - Defined:
    - The sequencer keeps last_addr and a last_valid bit.
    - last_valid is cleared on reset and set after each ADDR state.
    - When a popped entry has cur_addr == last_addr and last_valid=1, the sequencer goes IDLE→GAP, skipping ADDR. This saves 1 cycle per repeated address.
  - Not defined: every entry issues ADDR.

## Test plan
- Reset, then push (8'h20, 8'hC7) once. Required sequence:
  - `write`=1/`a0`=0/`dout`=20 at cycle 2
  - `write`=0 at cycle 3
  - `write`=1/`a0`=1/`dout`=C7 at cycle 4
  - `idle`=1 only after `busy` has pulsed high and then low
- Push 16 entries back-to-back with AW=4 and `busy` held high:
  - `full`=1 and `level`=16 (the first pop frees a slot, so the 17th push is accepted)
  - the 18th push leaves `ovf`=1
  - pulse `ovf_clr` → `ovf`=0
- Hold `busy`=1 from the start, then push (8'h08, 8'h78):
  - ADDR is issued
  - the sequencer stalls in GAP
  - DATA is issued exactly 1 cycle after `busy` falls
- Push 3 entries with a model register block whose `busy` lasts 32 cycles:
  - exactly 3 address strobes and 3 data strobes
  - data strobes spaced at ≥38 cycles
  - `write` is never high for 2 consecutive cycles
- Assert `rst` during WAIT with 5 entries queued:
  - next cycle `empty`=1, `level`=0, `write`=0
  - no further strobes
- With `JT51_WRQ_ADDRSKIP_EN` defined, push (8'h19, 8'h10) then (8'h19, 8'h85):
  - the second entry produces only a data strobe with `dout`=85
  - without the macro, it produces both an address strobe and a data strobe
